// File: rtl/ascon_rate_packer.sv
// ascon_rate_packer: packs BUS_W-bit bdi words into RATE_W-bit absorb blocks with ASCON 10* padding
// Ports: clk_i/rst_n_i clock and async active-low reset; bd_* input word stream (bdi_ready_o
// handshake, first byte in MSBs, contiguous byte mask); flush_i sync abort; blk_* padded
// block output with valid/ready handshake; seg_empty_o pulse for an empty AD segment;
// err_o sticky protocol error.
module ascon_rate_packer #(
    parameter int         BUS_W   = 32,
    parameter int         RATE_W  = 64,
    parameter logic [2:0] AD_TYPE = 3'd1,
    localparam int        BYTES   = BUS_W / 8,
    localparam int        RBYTES  = RATE_W / 8,
    localparam int        CW      = $clog2(RBYTES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [BUS_W-1:0]  bd_i,
    input  logic              bd_valid_i,
    input  logic [2:0]        bd_type_i,
    input  logic              bd_last_i,
    input  logic [BYTES-1:0]  bd_vld_byte_i,
    output logic              bdi_ready_o,
    input  logic              flush_i,
    output logic [RATE_W-1:0] blk_o,
    output logic              blk_valid_o,
    input  logic              blk_ready_i,
    output logic [2:0]        blk_type_o,
    output logic              blk_last_o,
    output logic              blk_pad_o,
    output logic [CW-1:0]     blk_bytes_o,
    output logic              seg_empty_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD, PADB} state_t;

    localparam logic [RATE_W-1:0] PAD_BLK = {8'h80, {(RATE_W-8){1'b0}}};

    state_t            state_q, state_d;
    logic [RATE_W-1:0] acc_q, acc_d, blk_q, blk_d;
    logic [CW-1:0]     fill_q, fill_d, blk_bytes_q, blk_bytes_d;
    logic [2:0]        type_q, type_d, blk_type_q, blk_type_d;
    logic              blk_valid_q, blk_valid_d, blk_last_q, blk_last_d, blk_pad_q, blk_pad_d;
    logic              seg_empty_q, seg_empty_d, err_q, err_d, pend_q, pend_d;
    logic [BYTES-1:0]  mask_inv;
    logic [BUS_W-1:0]  word_m;
    logic [CW-1:0]     n, fill_n;
    logic [RATE_W-1:0] merged, padded;
    logic              bad;

    always_comb begin
        // contiguous-from-MSB masks have an inverse of the form 0..01..1
        mask_inv = ~bd_vld_byte_i;
        n        = CW'($countones(bd_vld_byte_i));
        fill_n   = fill_q + n;
        word_m   = '0;
        for (int i = 0; i < BYTES; i++)
            word_m[i*8 +: 8] = bd_vld_byte_i[i] ? bd_i[i*8 +: 8] : 8'h00;
        merged = acc_q | ((RATE_W'(word_m) << (RATE_W - BUS_W)) >> {fill_q, 3'b000});
        // a shift by the full width drops the pad byte for an exactly full block
        padded = merged | (PAD_BLK >> {fill_n, 3'b000});
        bad    = ((mask_inv & (mask_inv + BYTES'(1))) != '0) ||
                 (!bd_last_i && n != CW'(BYTES)) ||
                 (fill_q != '0 && bd_type_i != type_q);
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        type_d      = type_q;
        blk_d       = blk_q;
        blk_valid_d = blk_valid_q;
        blk_type_d  = blk_type_q;
        blk_last_d  = blk_last_q;
        blk_pad_d   = blk_pad_q;
        blk_bytes_d = blk_bytes_q;
        seg_empty_d = 1'b0;
        err_d       = err_q;
        pend_d      = pend_q;
        if (flush_i) begin
            state_d     = FILL;
            acc_d       = '0;
            fill_d      = '0;
            blk_valid_d = 1'b0;
            pend_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = FILL;
                FILL: if (bd_valid_i) begin
                    if (bad)
                        err_d = 1'b1;
                    else if (bd_last_i && bd_vld_byte_i == '0 && fill_q == '0 && bd_type_i == AD_TYPE)
                        seg_empty_d = 1'b1;
                    else if (bd_last_i || fill_n == CW'(RBYTES)) begin
                        // a full last block defers its pad byte to a separate pad-only block
                        state_d     = HOLD;
                        blk_d       = padded;
                        blk_valid_d = 1'b1;
                        blk_type_d  = bd_type_i;
                        blk_last_d  = bd_last_i && fill_n != CW'(RBYTES);
                        blk_pad_d   = fill_n != CW'(RBYTES);
                        blk_bytes_d = fill_n;
                        pend_d      = bd_last_i && fill_n == CW'(RBYTES);
                        acc_d       = '0;
                        fill_d      = '0;
                    end else begin
                        acc_d  = merged;
                        fill_d = fill_n;
                        type_d = bd_type_i;
                    end
                end
                HOLD: if (blk_ready_i) begin
                    state_d     = pend_q ? PADB : FILL;
                    blk_valid_d = pend_q;
                    blk_d       = pend_q ? PAD_BLK : blk_q;
                    blk_last_d  = pend_q | blk_last_q;
                    blk_pad_d   = pend_q | blk_pad_q;
                    blk_bytes_d = pend_q ? '0 : blk_bytes_q;
                    pend_d      = 1'b0;
                end
                PADB: if (blk_ready_i) begin
                    state_d     = FILL;
                    blk_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            fill_q      <= '0;
            type_q      <= '0;
            blk_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_type_q  <= '0;
            blk_last_q  <= 1'b0;
            blk_pad_q   <= 1'b0;
            blk_bytes_q <= '0;
            seg_empty_q <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            type_q      <= type_d;
            blk_q       <= blk_d;
            blk_valid_q <= blk_valid_d;
            blk_type_q  <= blk_type_d;
            blk_last_q  <= blk_last_d;
            blk_pad_q   <= blk_pad_d;
            blk_bytes_q <= blk_bytes_d;
            seg_empty_q <= seg_empty_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
        end
    end

    assign bdi_ready_o = state_q == FILL;
    assign blk_o       = blk_q;
    assign blk_valid_o = blk_valid_q;
    assign blk_type_o  = blk_type_q;
    assign blk_last_o  = blk_last_q;
    assign blk_pad_o   = blk_pad_q;
    assign blk_bytes_o = blk_bytes_q;
    assign seg_empty_o = seg_empty_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_ascon_rate_packer.sv
// tb_ascon_rate_packer: table vectors, corner sequences and a byte-level random model for ascon_rate_packer
module tb_ascon_rate_packer;
    logic        clk = 1'b0, rst_n_i = 1'b0;
    logic [31:0] bd_i = '0;
    logic        bd_valid_i = 1'b0, bd_last_i = 1'b0, flush_i = 1'b0, blk_ready_i = 1'b0;
    logic [2:0]  bd_type_i = '0;
    logic [3:0]  bd_vld_byte_i = '0;
    logic        bdi_ready_o, blk_valid_o, blk_last_o, blk_pad_o, seg_empty_o, err_o;
    logic [63:0] blk_o;
    logic [2:0]  blk_type_o;
    logic [3:0]  blk_bytes_o;

    ascon_rate_packer #(.BUS_W(32), .RATE_W(64), .AD_TYPE(3'd1)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .bd_i(bd_i), .bd_valid_i(bd_valid_i),
        .bd_type_i(bd_type_i), .bd_last_i(bd_last_i), .bd_vld_byte_i(bd_vld_byte_i),
        .bdi_ready_o(bdi_ready_o), .flush_i(flush_i), .blk_o(blk_o), .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i), .blk_type_o(blk_type_o), .blk_last_o(blk_last_o),
        .blk_pad_o(blk_pad_o), .blk_bytes_o(blk_bytes_o), .seg_empty_o(seg_empty_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] t; int nw; logic [31:0] w0; logic [3:0] m0; logic [31:0] w1; logic [3:0] m1;
        logic lst; logic [63:0] eb; logic [3:0] en; logic el; logic ep;
    } vec_t;
    typedef struct {logic [31:0] d; logic [3:0] m; logic l; logic [2:0] t;} word_t;
    typedef struct {logic [63:0] b; logic [3:0] n; logic l; logic p; logic [2:0] t;} blk_t;

    int    n_vec = 0, n_bad = 0, exp_empty = 0, got_empty = 0;
    vec_t  vt[8];
    word_t wq[$];
    blk_t  bq[$];
    logic [63:0] held;

    task automatic chk(input string nm, input logic [79:0] a, input logic [79:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic do_reset();
        #2 rst_n_i = 1'b0;
        bd_valid_i = 1'b0; blk_ready_i = 1'b0; flush_i = 1'b0;
        #1 chk("reset_outputs", {blk_valid_o, bdi_ready_o, err_o, seg_empty_o, blk_last_o, blk_pad_o,
                                 blk_type_o, blk_bytes_o, blk_o}, 80'd0);
        @(negedge clk) rst_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] m, input logic l, input logic [2:0] t);
        int c = 0;
        bd_i = d; bd_vld_byte_i = m; bd_last_i = l; bd_type_i = t; bd_valid_i = 1'b1;
        while (!bdi_ready_o && c < 50) begin @(negedge clk); c++; end
        if (!bdi_ready_o) chk("send_ready_timeout", {79'd0, bdi_ready_o}, 80'd1);
        @(negedge clk) bd_valid_i = 1'b0;
    endtask

    task automatic consume();
        blk_ready_i = 1'b1;
        @(negedge clk) blk_ready_i = 1'b0;
    endtask

    task automatic build_model();
        for (int s = 0; s < 40; s++) begin
            logic [2:0] t; int len, nw; logic [7:0] sb[$]; blk_t e; word_t w;
            t   = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 19);
            sb.delete();
            for (int i = 0; i < len; i++) sb.push_back(8'($urandom));
            for (int k = 0; k < len / 8; k++) begin
                e.b = '0;
                for (int j = 0; j < 8; j++) e.b[63-8*j -: 8] = sb[8*k+j];
                e.n = 4'd8; e.l = 1'b0; e.p = 1'b0; e.t = t;
                bq.push_back(e);
            end
            if (len % 8 != 0) begin
                e.b = '0;
                for (int j = 0; j < len % 8; j++) e.b[63-8*j -: 8] = sb[8*(len/8)+j];
                e.b[63-8*(len%8) -: 8] = 8'h80;
                e.n = 4'(len % 8); e.l = 1'b1; e.p = 1'b1; e.t = t;
                bq.push_back(e);
            end else if (len == 0 && t == 3'd1) exp_empty++;
            else begin
                e.b = 64'h8000_0000_0000_0000; e.n = 4'd0; e.l = 1'b1; e.p = 1'b1; e.t = t;
                bq.push_back(e);
            end
            nw = (len == 0) ? 1 : (len + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                w.d = $urandom; w.m = '0;
                for (int j = 0; j < 4; j++)
                    if (4*k + j < len) begin w.m[3-j] = 1'b1; w.d[31-8*j -: 8] = sb[4*k+j]; end
                w.l = (k == nw - 1); w.t = t;
                wq.push_back(w);
            end
        end
    endtask

    task automatic run_random();
        int idx = 0, cyc = 0; blk_t e;
        while ((idx < wq.size() || bq.size() != 0 || blk_valid_o) && cyc < 20000) begin
            if (idx < wq.size()) begin
                bd_i = wq[idx].d; bd_vld_byte_i = wq[idx].m; bd_last_i = wq[idx].l; bd_type_i = wq[idx].t;
                bd_valid_i = ($urandom_range(0, 3) != 0);
            end else bd_valid_i = 1'b0;
            blk_ready_i = ($urandom_range(0, 2) != 0);
            if (seg_empty_o) got_empty++;
            if (blk_valid_o && blk_ready_i) begin
                if (bq.size() == 0) chk("rnd_extra_blk", {79'd0, blk_valid_o}, 80'd0);
                else begin
                    e = bq.pop_front();
                    chk("rnd_blk", {blk_o, blk_bytes_o, blk_last_o, blk_pad_o, blk_type_o},
                        {e.b, e.n, e.l, e.p, e.t});
                end
            end
            if (bd_valid_i && bdi_ready_o) idx++;
            @(negedge clk); cyc++;
        end
        bd_valid_i = 1'b0; blk_ready_i = 1'b0;
        repeat (3) begin if (seg_empty_o) got_empty++; @(negedge clk); end
        chk("rnd_words_left", 80'(wq.size() - idx), 80'd0);
        chk("rnd_blks_left", 80'(bq.size()), 80'd0);
        chk("rnd_seg_empty", 80'(got_empty), 80'(exp_empty));
        chk("rnd_err", {79'd0, err_o}, 80'd0);
    endtask

    initial begin
        #1000000 $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{3'd2, 1, 32'hAABBCCDD, 4'b1100, 32'h0, 4'b0, 1'b1, 64'hAABB800000000000, 4'd2, 1'b1, 1'b1};
        vt[1] = '{3'd2, 1, 32'h12345678, 4'b0000, 32'h0, 4'b0, 1'b1, 64'h8000000000000000, 4'd0, 1'b1, 1'b1};
        vt[2] = '{3'd1, 1, 32'h11223344, 4'b1111, 32'h0, 4'b0, 1'b1, 64'h1122334480000000, 4'd4, 1'b1, 1'b1};
        vt[3] = '{3'd2, 2, 32'h11223344, 4'b1111, 32'h55667788, 4'b1110, 1'b1, 64'h1122334455667780, 4'd7, 1'b1, 1'b1};
        vt[4] = '{3'd1, 1, 32'hDEADBEEF, 4'b1000, 32'h0, 4'b0, 1'b1, 64'hDE80000000000000, 4'd1, 1'b1, 1'b1};
        vt[5] = '{3'd4, 2, 32'h01020304, 4'b1111, 32'h05060708, 4'b1000, 1'b1, 64'h0102030405800000, 4'd5, 1'b1, 1'b1};
        vt[6] = '{3'd1, 2, 32'hCAFEF00D, 4'b1111, 32'hFFFFFFFF, 4'b0000, 1'b1, 64'hCAFEF00D80000000, 4'd4, 1'b1, 1'b1};
        vt[7] = '{3'd3, 2, 32'h01020304, 4'b1111, 32'h05060708, 4'b1111, 1'b0, 64'h0102030405060708, 4'd8, 1'b0, 1'b0};
        do_reset();
        chk("idle_to_fill", {79'd0, bdi_ready_o}, 80'd1);
        for (int i = 0; i < 8; i++) begin
            if (vt[i].nw == 2) send(vt[i].w0, vt[i].m0, 1'b0, vt[i].t);
            send(vt[i].nw == 2 ? vt[i].w1 : vt[i].w0, vt[i].nw == 2 ? vt[i].m1 : vt[i].m0, vt[i].lst, vt[i].t);
            chk($sformatf("vec%0d", i), {blk_valid_o, blk_o, blk_bytes_o, blk_last_o, blk_pad_o, blk_type_o},
                {1'b1, vt[i].eb, vt[i].en, vt[i].el, vt[i].ep, vt[i].t});
            consume();
            chk($sformatf("vec%0d_drain", i), {blk_valid_o, bdi_ready_o}, 80'b01);
        end
        // full AD block with last: data block then pad-only block
        send(32'h11223344, 4'b1111, 1'b0, 3'd1);
        send(32'h55667788, 4'b1111, 1'b1, 3'd1);
        chk("ad_full", {blk_valid_o, bdi_ready_o, blk_o, blk_bytes_o, blk_last_o, blk_pad_o},
            {2'b10, 64'h1122334455667788, 4'd8, 1'b0, 1'b0});
        consume();
        chk("ad_padb", {blk_valid_o, bdi_ready_o, blk_o, blk_bytes_o, blk_last_o, blk_pad_o, blk_type_o},
            {2'b10, 64'h8000000000000000, 4'd0, 1'b1, 1'b1, 3'd1});
        consume();
        chk("ad_padb_done", {blk_valid_o, bdi_ready_o}, 80'b01);
        // empty AD segment
        send(32'h9999AAAA, 4'b0000, 1'b1, 3'd1);
        chk("ad_empty_pulse", {seg_empty_o, blk_valid_o}, 80'b10);
        @(negedge clk);
        chk("ad_empty_end", {seg_empty_o, blk_valid_o}, 80'b00);
        // consumer stall
        send(32'h0A0B0C0D, 4'b1111, 1'b0, 3'd2);
        send(32'h0E0F1011, 4'b1111, 1'b0, 3'd2);
        repeat (5) begin
            held = blk_o;
            @(negedge clk);
            chk("stall_hold", {blk_valid_o, bdi_ready_o, blk_o}, {2'b10, held});
        end
        chk("stall_blk", blk_o, 64'h0A0B0C0D0E0F1011);
        consume();
        chk("stall_done", {blk_valid_o, bdi_ready_o}, 80'b01);
        // flush drops a partial block
        send(32'h77777777, 4'b1111, 1'b0, 3'd2);
        flush_i = 1'b1;
        @(negedge clk) flush_i = 1'b0;
        chk("flush_idle", {blk_valid_o, bdi_ready_o}, 80'b01);
        send(32'hCAFEBABE, 4'b1111, 1'b0, 3'd2);
        send(32'h01234567, 4'b1111, 1'b0, 3'd2);
        chk("flush_fresh", {blk_valid_o, blk_o, blk_bytes_o}, {1'b1, 64'hCAFEBABE01234567, 4'd8});
        consume();
        // flush during handshake of a full last block suppresses the pad-only block
        send(32'h10203040, 4'b1111, 1'b0, 3'd5);
        send(32'h50607080, 4'b1111, 1'b1, 3'd5);
        blk_ready_i = 1'b1; flush_i = 1'b1;
        @(negedge clk) begin blk_ready_i = 1'b0; flush_i = 1'b0; end
        chk("flush_hs", {blk_valid_o, bdi_ready_o}, 80'b01);
        @(negedge clk);
        chk("flush_hs_nopad", {blk_valid_o, bdi_ready_o}, 80'b01);
        // randomized traffic against the byte-level model
        build_model();
        run_random();
        // non-contiguous mask: sticky error, word dropped
        send(32'hFFFFFFFF, 4'b1010, 1'b0, 3'd2);
        chk("err_mask", {err_o, blk_valid_o}, 80'b10);
        send(32'h21222324, 4'b1111, 1'b0, 3'd2);
        send(32'h25262728, 4'b1111, 1'b0, 3'd2);
        chk("err_dropped", {err_o, blk_valid_o, blk_o}, {2'b11, 64'h2122232425262728});
        consume();
        do_reset();
        chk("err_cleared", {79'd0, err_o}, 80'd0);
        // type change mid-block
        send(32'hA1A2A3A4, 4'b1111, 1'b0, 3'd2);
        send(32'hB1B2B3B4, 4'b1111, 1'b0, 3'd3);
        chk("err_type", {err_o, blk_valid_o}, 80'b10);
        send(32'hC1C2C3C4, 4'b1111, 1'b0, 3'd2);
        chk("err_type_drop", {blk_valid_o, blk_o}, {1'b1, 64'hA1A2A3A4C1C2C3C4});
        consume();
        do_reset();
        // partial word without last
        send(32'hD1D2D3D4, 4'b1100, 1'b0, 3'd2);
        chk("err_partial", {79'd0, err_o}, 80'd1);
        // async reset in the middle of a block loses the partial data
        do_reset();
        send(32'hE1E2E3E4, 4'b1111, 1'b0, 3'd2);
        do_reset();
        send(32'hF1F2F3F4, 4'b1111, 1'b0, 3'd2);
        send(32'hF5F6F7F8, 4'b1111, 1'b0, 3'd2);
        chk("reset_midop", {blk_valid_o, err_o, blk_o}, {2'b10, 64'hF1F2F3F4F5F6F7F8});
        consume();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
